// File: rtl/reorder_buffer_if.sv
// Issue, writeback, operand-query and commit bundle of the reorder buffer.
// master = pipeline side driving requests, slave = the reorder buffer.
interface reorder_buffer_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 issue;
    logic [1:0]           kind_issue;
    logic [4:0]           rd_issue;
    logic                 pred_taken_issue;
    logic [31:0]          alt_pc_issue;
    logic [ROB_WIDTH-1:0] issue_tag;
    logic                 full;

    logic [ROB_WIDTH-1:0] query_tag_1;
    logic [ROB_WIDTH-1:0] query_tag_2;
    logic                 query_ready_1;
    logic                 query_ready_2;
    logic [31:0]          query_value_1;
    logic [31:0]          query_value_2;

    logic                 done_alu_1;
    logic [31:0]          value_alu_1;
    logic [ROB_WIDTH-1:0] tag_alu_1;
    logic                 done_alu_2;
    logic [31:0]          value_alu_2;
    logic [ROB_WIDTH-1:0] tag_alu_2;
    logic                 done_lsb;
    logic [31:0]          value_lsb;
    logic [ROB_WIDTH-1:0] tag_lsb;

    logic                 done_commit;
    logic [31:0]          value_commit;
    logic [ROB_WIDTH-1:0] tag_commit;
    logic [4:0]           rd_commit;
    logic                 store_commit;
    logic [ROB_WIDTH-1:0] store_tag;
    logic                 clear_signal;
    logic [31:0]          redirect_pc;

    modport master (
        output issue, kind_issue, rd_issue, pred_taken_issue, alt_pc_issue,
        input  issue_tag, full,
        output query_tag_1, query_tag_2,
        input  query_ready_1, query_ready_2, query_value_1, query_value_2,
        output done_alu_1, value_alu_1, tag_alu_1,
        output done_alu_2, value_alu_2, tag_alu_2,
        output done_lsb, value_lsb, tag_lsb,
        input  done_commit, value_commit, tag_commit, rd_commit,
        input  store_commit, store_tag, clear_signal, redirect_pc
    );

    modport slave (
        input  issue, kind_issue, rd_issue, pred_taken_issue, alt_pc_issue,
        output issue_tag, full,
        input  query_tag_1, query_tag_2,
        output query_ready_1, query_ready_2, query_value_1, query_value_2,
        input  done_alu_1, value_alu_1, tag_alu_1,
        input  done_alu_2, value_alu_2, tag_alu_2,
        input  done_lsb, value_lsb, tag_lsb,
        output done_commit, value_commit, tag_commit, rd_commit,
        output store_commit, store_tag, clear_signal, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue with tag allocation, writeback capture and commit broadcast.
// Define ROB_BYPASS_EN to let operand queries see same-cycle writebacks.
module reorder_buffer #(
    parameter int ROB_WIDTH = 4,
    parameter int ROB_SIZE  = 2**ROB_WIDTH
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    reorder_buffer_if.slave   rob
);
    typedef enum logic [1:0] {
        KIND_REG    = 2'b00,
        KIND_STORE  = 2'b01,
        KIND_BRANCH = 2'b10,
        KIND_REG_X  = 2'b11
    } kind_e;

    // Control state (reset)
    logic [ROB_SIZE-1:0]  busy_q, busy_d;
    logic [ROB_SIZE-1:0]  ready_q, ready_d;
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    // Entry payload (no reset)
    kind_e                kind_q   [ROB_SIZE];
    logic [4:0]           rd_q     [ROB_SIZE];
    logic [31:0]          value_q  [ROB_SIZE];
    logic [31:0]          alt_pc_q [ROB_SIZE];
    logic [ROB_SIZE-1:0]  pred_q;

    // Registered outputs
    logic                 done_commit_q, done_commit_d;
    logic [31:0]          value_commit_q, value_commit_d;
    logic [ROB_WIDTH-1:0] tag_commit_q, tag_commit_d;
    logic [4:0]           rd_commit_q, rd_commit_d;
    logic                 store_commit_q, store_commit_d;
    logic [ROB_WIDTH-1:0] store_tag_q, store_tag_d;
    logic                 clear_q, clear_d;
    logic [31:0]          redirect_q, redirect_d;

    logic full;
    logic issue_acc;
    logic wb_acc_1, wb_acc_2, wb_acc_lsb;
    logic commit;
    logic mispredict;

    assign full       = (count_q == (ROB_WIDTH+1)'(ROB_SIZE));
    assign issue_acc  = rob.issue & ~full & ~clear_q;
    assign wb_acc_1   = rob.done_alu_1 & busy_q[rob.tag_alu_1] & ~clear_q;
    assign wb_acc_2   = rob.done_alu_2 & busy_q[rob.tag_alu_2] & ~clear_q;
    assign wb_acc_lsb = rob.done_lsb   & busy_q[rob.tag_lsb]   & ~clear_q;
    assign commit     = busy_q[head_q] & ready_q[head_q] & ~clear_q;
    assign mispredict = commit && (kind_q[head_q] == KIND_BRANCH)
                        && (value_q[head_q][0] != pred_q[head_q]);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        busy_d         = busy_q;
        ready_d        = ready_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        done_commit_d  = 1'b0;
        value_commit_d = value_commit_q;
        tag_commit_d   = tag_commit_q;
        rd_commit_d    = rd_commit_q;
        store_commit_d = 1'b0;
        store_tag_d    = store_tag_q;
        clear_d        = 1'b0;
        redirect_d     = redirect_q;

        if (mispredict) begin
            // Flush wins over any issue or writeback arriving on the same edge.
            busy_d     = '0;
            ready_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            clear_d    = 1'b1;
            redirect_d = alt_pc_q[head_q];
        end else begin
            if (commit) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
                case (kind_q[head_q])
                    KIND_STORE: begin
                        store_commit_d = 1'b1;
                        store_tag_d    = head_q;
                    end
                    KIND_BRANCH: ;
                    default: begin
                        done_commit_d  = 1'b1;
                        value_commit_d = value_q[head_q];
                        tag_commit_d   = head_q;
                        rd_commit_d    = rd_q[head_q];
                    end
                endcase
            end
            if (wb_acc_1)   ready_d[rob.tag_alu_1] = 1'b1;
            if (wb_acc_2)   ready_d[rob.tag_alu_2] = 1'b1;
            if (wb_acc_lsb) ready_d[rob.tag_lsb]   = 1'b1;
            if (issue_acc) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            case ({issue_acc, commit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q         <= '0;
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            done_commit_q  <= 1'b0;
            value_commit_q <= '0;
            tag_commit_q   <= '0;
            rd_commit_q    <= '0;
            store_commit_q <= 1'b0;
            store_tag_q    <= '0;
            clear_q        <= 1'b0;
            redirect_q     <= '0;
        end else if (rdy_in) begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            done_commit_q  <= done_commit_d;
            value_commit_q <= value_commit_d;
            tag_commit_q   <= tag_commit_d;
            rd_commit_q    <= rd_commit_d;
            store_commit_q <= store_commit_d;
            store_tag_q    <= store_tag_d;
            clear_q        <= clear_d;
            redirect_q     <= redirect_d;
        end
    end

    // NOTE: payload storage is not reset; busy/ready gate every read, so stale contents are never observed.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !mispredict) begin
            if (issue_acc) begin
                kind_q[tail_q]   <= kind_e'(rob.kind_issue);
                rd_q[tail_q]     <= rob.rd_issue;
                pred_q[tail_q]   <= rob.pred_taken_issue;
                alt_pc_q[tail_q] <= rob.alt_pc_issue;
            end
            if (wb_acc_1)   value_q[rob.tag_alu_1] <= rob.value_alu_1;
            if (wb_acc_2)   value_q[rob.tag_alu_2] <= rob.value_alu_2;
            if (wb_acc_lsb) value_q[rob.tag_lsb]   <= rob.value_lsb;
        end
    end

    logic [ROB_WIDTH-1:0] qry_tag   [2];
    logic [1:0]           qry_ready;
    logic [31:0]          qry_value [2];

    assign qry_tag[0] = rob.query_tag_1;
    assign qry_tag[1] = rob.query_tag_2;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            qry_ready[i] = busy_q[qry_tag[i]] & ready_q[qry_tag[i]];
            qry_value[i] = value_q[qry_tag[i]];
`ifdef ROB_BYPASS_EN
            if (busy_q[qry_tag[i]]) begin
                if (rob.done_alu_1 && rob.tag_alu_1 == qry_tag[i]) begin
                    qry_ready[i] = 1'b1;
                    qry_value[i] = rob.value_alu_1;
                end else if (rob.done_alu_2 && rob.tag_alu_2 == qry_tag[i]) begin
                    qry_ready[i] = 1'b1;
                    qry_value[i] = rob.value_alu_2;
                end else if (rob.done_lsb && rob.tag_lsb == qry_tag[i]) begin
                    qry_ready[i] = 1'b1;
                    qry_value[i] = rob.value_lsb;
                end
            end
`endif
        end
    end

    assign rob.issue_tag     = tail_q;
    assign rob.full          = full;
    assign rob.query_ready_1 = qry_ready[0];
    assign rob.query_ready_2 = qry_ready[1];
    assign rob.query_value_1 = qry_value[0];
    assign rob.query_value_2 = qry_value[1];
    assign rob.done_commit   = done_commit_q;
    assign rob.value_commit  = value_commit_q;
    assign rob.tag_commit    = tag_commit_q;
    assign rob.rd_commit     = rd_commit_q;
    assign rob.store_commit  = store_commit_q;
    assign rob.store_tag     = store_tag_q;
    assign rob.clear_signal  = clear_q;
    assign rob.redirect_pc   = redirect_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_reorder_buffer;
    localparam int W = 4;
    localparam int N = 16;
`ifdef ROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    always #5 clk_in = ~clk_in;

    reorder_buffer_if #(.ROB_WIDTH(W)) rob ();
    reorder_buffer #(.ROB_WIDTH(W)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob(rob));

    typedef struct {
        logic [W-1:0] tag;
        logic [1:0]   kind;
        logic [4:0]   rd;
        logic         pred;
        logic [31:0]  alt;
        logic         rdy;
        logic [31:0]  val;
    } ent_t;

    // Program-order queue: front is the oldest un-retired instruction.
    ent_t         m_q[$];
    int           m_next_tag;
    logic         m_done, m_store, m_clear;
    logic [31:0]  m_value, m_redirect;
    logic [W-1:0] m_tag, m_store_tag;
    logic [4:0]   m_rd;
    int           total = 0;
    int           bad = 0;

    task automatic set_idle();
        rdy_in = 1'b1;
        rob.issue = 1'b0; rob.kind_issue = 2'd0; rob.rd_issue = 5'd0;
        rob.pred_taken_issue = 1'b0; rob.alt_pc_issue = 32'd0;
        rob.done_alu_1 = 1'b0; rob.value_alu_1 = 32'd0; rob.tag_alu_1 = '0;
        rob.done_alu_2 = 1'b0; rob.value_alu_2 = 32'd0; rob.tag_alu_2 = '0;
        rob.done_lsb = 1'b0; rob.value_lsb = 32'd0; rob.tag_lsb = '0;
        rob.query_tag_1 = '0; rob.query_tag_2 = '0;
    endtask

    function automatic void model_wb(input logic [W-1:0] t, input logic [31:0] v);
        ent_t e;
        foreach (m_q[i]) begin
            if (m_q[i].tag == t) begin
                e = m_q[i]; e.rdy = 1'b1; e.val = v; m_q[i] = e;
            end
        end
    endfunction

    task automatic model_step();
        bit   was_clear;
        bit   was_full;
        bit   flushed;
        ent_t h;
        ent_t n;
        was_clear = m_clear;
        was_full  = (m_q.size() == N);
        flushed   = 1'b0;
        if (rdy_in) begin
            m_done = 1'b0; m_store = 1'b0; m_clear = 1'b0;
            if (!was_clear) begin
                if (m_q.size() > 0 && m_q[0].rdy) begin
                    h = m_q.pop_front();
                    if (h.kind == 2'd2) begin
                        if (h.val[0] != h.pred) begin
                            m_clear = 1'b1; m_redirect = h.alt;
                            m_q.delete(); m_next_tag = 0; flushed = 1'b1;
                        end
                    end else if (h.kind == 2'd1) begin
                        m_store = 1'b1; m_store_tag = h.tag;
                    end else begin
                        m_done = 1'b1; m_value = h.val; m_tag = h.tag; m_rd = h.rd;
                    end
                end
                if (!flushed) begin
                    if (rob.done_alu_1) model_wb(rob.tag_alu_1, rob.value_alu_1);
                    if (rob.done_alu_2) model_wb(rob.tag_alu_2, rob.value_alu_2);
                    if (rob.done_lsb)   model_wb(rob.tag_lsb, rob.value_lsb);
                    if (rob.issue && !was_full) begin
                        n.tag = W'(m_next_tag); n.kind = rob.kind_issue; n.rd = rob.rd_issue;
                        n.pred = rob.pred_taken_issue; n.alt = rob.alt_pc_issue;
                        n.rdy = 1'b0; n.val = 32'd0;
                        m_q.push_back(n);
                        m_next_tag = (m_next_tag + 1) % N;
                    end
                end
            end
        end
    endtask

    function automatic void exp_query(input logic [W-1:0] t, output logic r, output logic [31:0] v);
        r = 1'b0; v = 32'd0;
        foreach (m_q[i]) begin
            if (m_q[i].tag == t) begin
                r = m_q[i].rdy; v = m_q[i].val;
                if (BYP) begin
                    if (rob.done_lsb && rob.tag_lsb == t) begin r = 1'b1; v = rob.value_lsb; end
                    if (rob.done_alu_2 && rob.tag_alu_2 == t) begin r = 1'b1; v = rob.value_alu_2; end
                    if (rob.done_alu_1 && rob.tag_alu_1 == t) begin r = 1'b1; v = rob.value_alu_1; end
                end
            end
        end
    endfunction

    // One clock: check combinational outputs, advance the model, clock the DUT, check registered outputs.
    task automatic step();
        logic         r;
        logic [31:0]  v;
        logic [W-1:0] et;
        #1;
        exp_query(rob.query_tag_1, r, v);
        total++; if (rob.query_ready_1 !== r) begin bad++; $display("FAIL query_ready_1: got %0h want %0h", rob.query_ready_1, r); end
        if (r) begin total++; if (rob.query_value_1 !== v) begin bad++; $display("FAIL query_value_1: got %0h want %0h", rob.query_value_1, v); end end
        exp_query(rob.query_tag_2, r, v);
        total++; if (rob.query_ready_2 !== r) begin bad++; $display("FAIL query_ready_2: got %0h want %0h", rob.query_ready_2, r); end
        if (r) begin total++; if (rob.query_value_2 !== v) begin bad++; $display("FAIL query_value_2: got %0h want %0h", rob.query_value_2, v); end end
        et = W'(m_next_tag);
        total++; if (rob.issue_tag !== et) begin bad++; $display("FAIL issue_tag: got %0h want %0h", rob.issue_tag, et); end
        total++; if (rob.full !== (m_q.size() == N)) begin bad++; $display("FAIL full: got %0h want %0h", rob.full, (m_q.size() == N)); end
        model_step();
        @(posedge clk_in); #1;
        total++; if (rob.done_commit !== m_done) begin bad++; $display("FAIL done_commit: got %0h want %0h", rob.done_commit, m_done); end
        total++; if (rob.store_commit !== m_store) begin bad++; $display("FAIL store_commit: got %0h want %0h", rob.store_commit, m_store); end
        total++; if (rob.clear_signal !== m_clear) begin bad++; $display("FAIL clear_signal: got %0h want %0h", rob.clear_signal, m_clear); end
        if (m_done) begin
            total++; if (rob.value_commit !== m_value) begin bad++; $display("FAIL value_commit: got %0h want %0h", rob.value_commit, m_value); end
            total++; if (rob.tag_commit !== m_tag) begin bad++; $display("FAIL tag_commit: got %0h want %0h", rob.tag_commit, m_tag); end
            total++; if (rob.rd_commit !== m_rd) begin bad++; $display("FAIL rd_commit: got %0h want %0h", rob.rd_commit, m_rd); end
        end
        if (m_store) begin
            total++; if (rob.store_tag !== m_store_tag) begin bad++; $display("FAIL store_tag: got %0h want %0h", rob.store_tag, m_store_tag); end
        end
        if (m_clear) begin
            total++; if (rob.redirect_pc !== m_redirect) begin bad++; $display("FAIL redirect_pc: got %0h want %0h", rob.redirect_pc, m_redirect); end
        end
        set_idle();
    endtask

    task automatic do_reset();
        set_idle();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        m_q.delete(); m_next_tag = 0;
        m_done = 1'b0; m_store = 1'b0; m_clear = 1'b0;
        m_value = '0; m_redirect = '0; m_tag = '0; m_store_tag = '0; m_rd = '0;
    endtask

    task automatic issue_one(input logic [1:0] kind, input logic [4:0] rd, input logic pred, input logic [31:0] alt);
        rob.issue = 1'b1; rob.kind_issue = kind; rob.rd_issue = rd;
        rob.pred_taken_issue = pred; rob.alt_pc_issue = alt;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rob.done_commit !== 1'b0) begin bad++; $display("FAIL reset_done_commit: got %0h want 0", rob.done_commit); end
        total++; if (rob.store_commit !== 1'b0) begin bad++; $display("FAIL reset_store_commit: got %0h want 0", rob.store_commit); end
        total++; if (rob.clear_signal !== 1'b0) begin bad++; $display("FAIL reset_clear: got %0h want 0", rob.clear_signal); end
        total++; if (rob.redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_redirect: got %0h want 0", rob.redirect_pc); end
        total++; if (rob.value_commit !== 32'd0) begin bad++; $display("FAIL reset_value_commit: got %0h want 0", rob.value_commit); end
        total++; if (rob.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0h want 0", rob.full); end
        total++; if (rob.issue_tag !== 4'd0) begin bad++; $display("FAIL reset_issue_tag: got %0h want 0", rob.issue_tag); end
    endtask

    task automatic test_basic_commit();
        do_reset();
        issue_one(2'd0, 5'd5, 1'b0, 32'd0);
        total++; if (rob.issue_tag !== 4'd0) begin bad++; $display("FAIL basic_issue_tag: got %0h want 0", rob.issue_tag); end
        step();
        rob.done_alu_1 = 1'b1; rob.tag_alu_1 = 4'd0; rob.value_alu_1 = 32'h1234;
        step();
        total++; if (rob.done_commit !== 1'b0) begin bad++; $display("FAIL basic_early_commit: got %0h want 0", rob.done_commit); end
        step();
        total++; if (rob.done_commit !== 1'b1) begin bad++; $display("FAIL basic_done_commit: got %0h want 1", rob.done_commit); end
        total++; if (rob.tag_commit !== 4'd0) begin bad++; $display("FAIL basic_tag: got %0h want 0", rob.tag_commit); end
        total++; if (rob.rd_commit !== 5'd5) begin bad++; $display("FAIL basic_rd: got %0h want 5", rob.rd_commit); end
        total++; if (rob.value_commit !== 32'h1234) begin bad++; $display("FAIL basic_value: got %0h want 1234", rob.value_commit); end
        step();
        total++; if (rob.done_commit !== 1'b0) begin bad++; $display("FAIL basic_pulse_width: got %0h want 0", rob.done_commit); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < N; i++) begin
            issue_one(2'd0, 5'(i), 1'b0, 32'd0);
            step();
        end
        total++; if (rob.full !== 1'b1) begin bad++; $display("FAIL full_at_16: got %0h want 1", rob.full); end
        issue_one(2'd0, 5'd31, 1'b0, 32'd0);
        step();
        rob.done_alu_1 = 1'b1; rob.tag_alu_1 = 4'd0; rob.value_alu_1 = 32'hCAFE;
        step();
        total++; if (rob.full !== 1'b1) begin bad++; $display("FAIL full_before_commit: got %0h want 1", rob.full); end
        step();
        total++; if (rob.full !== 1'b0) begin bad++; $display("FAIL full_after_commit: got %0h want 0", rob.full); end
        total++; if (rob.issue_tag !== 4'd0) begin bad++; $display("FAIL wrap_issue_tag: got %0h want 0", rob.issue_tag); end
        total++; if (rob.rd_commit !== 5'd0) begin bad++; $display("FAIL full_rd_commit: got %0h want 0", rob.rd_commit); end
        rob.done_alu_2 = 1'b1; rob.tag_alu_2 = 4'd1; rob.value_alu_2 = 32'h11;
        step();
        issue_one(2'd0, 5'd7, 1'b0, 32'd0);
        step();
        total++; if (rob.full !== 1'b0) begin bad++; $display("FAIL full_issue_and_commit: got %0h want 0", rob.full); end
        total++; if (rob.issue_tag !== 4'd1) begin bad++; $display("FAIL issue_tag_after_wrap: got %0h want 1", rob.issue_tag); end
        issue_one(2'd0, 5'd8, 1'b0, 32'd0);
        step();
        total++; if (rob.full !== 1'b1) begin bad++; $display("FAIL full_refill: got %0h want 1", rob.full); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue_one(2'd0, 5'(10 + i), 1'b0, 32'd0);
            step();
        end
        rob.done_alu_1 = 1'b1; rob.tag_alu_1 = 4'd2; rob.value_alu_1 = 32'hA2; step();
        rob.done_alu_2 = 1'b1; rob.tag_alu_2 = 4'd1; rob.value_alu_2 = 32'hA1; step();
        rob.done_lsb = 1'b1; rob.tag_lsb = 4'd0; rob.value_lsb = 32'hA0; step();
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (rob.done_commit !== 1'b1) begin bad++; $display("FAIL ooo_done_%0d: got %0h want 1", k, rob.done_commit); end
            total++; if (rob.tag_commit !== 4'(k)) begin bad++; $display("FAIL ooo_tag_%0d: got %0h want %0h", k, rob.tag_commit, k); end
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue_one(2'd2, 5'd0, 1'b1, 32'h100); step();
        issue_one(2'd0, 5'd3, 1'b0, 32'd0); step();
        rob.done_alu_2 = 1'b1; rob.tag_alu_2 = 4'd1; rob.value_alu_2 = 32'h55; step();
        rob.done_alu_1 = 1'b1; rob.tag_alu_1 = 4'd0; rob.value_alu_1 = 32'h0; step();
        issue_one(2'd0, 5'd9, 1'b0, 32'd0);
        step();
        total++; if (rob.clear_signal !== 1'b1) begin bad++; $display("FAIL mp_clear: got %0h want 1", rob.clear_signal); end
        total++; if (rob.redirect_pc !== 32'h100) begin bad++; $display("FAIL mp_redirect: got %0h want 100", rob.redirect_pc); end
        total++; if (rob.done_commit !== 1'b0) begin bad++; $display("FAIL mp_done_commit: got %0h want 0", rob.done_commit); end
        total++; if (rob.issue_tag !== 4'd0) begin bad++; $display("FAIL mp_issue_tag: got %0h want 0", rob.issue_tag); end
        issue_one(2'd0, 5'd9, 1'b0, 32'd0);
        step();
        total++; if (rob.clear_signal !== 1'b0) begin bad++; $display("FAIL mp_clear_pulse: got %0h want 0", rob.clear_signal); end
        total++; if (rob.issue_tag !== 4'd0) begin bad++; $display("FAIL mp_issue_during_clear: got %0h want 0", rob.issue_tag); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (rob.done_commit !== 1'b0) begin bad++; $display("FAIL mp_flushed_commit_%0d: got %0h want 0", k, rob.done_commit); end
        end
    endtask

    task automatic test_store();
        do_reset();
        issue_one(2'd1, 5'd4, 1'b0, 32'd0); step();
        rob.done_lsb = 1'b1; rob.tag_lsb = 4'd0; rob.value_lsb = $urandom; step();
        step();
        total++; if (rob.store_commit !== 1'b1) begin bad++; $display("FAIL st_commit: got %0h want 1", rob.store_commit); end
        total++; if (rob.store_tag !== 4'd0) begin bad++; $display("FAIL st_tag: got %0h want 0", rob.store_tag); end
        total++; if (rob.done_commit !== 1'b0) begin bad++; $display("FAIL st_done_commit: got %0h want 0", rob.done_commit); end
        step();
        total++; if (rob.store_commit !== 1'b0) begin bad++; $display("FAIL st_pulse_width: got %0h want 0", rob.store_commit); end
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue_one(2'd0, 5'(i + 1), 1'b0, 32'd0);
            step();
        end
        rob.done_alu_2 = 1'b1; rob.tag_alu_2 = 4'd3; rob.value_alu_2 = 32'hBEEF;
        rob.query_tag_1 = 4'd3; rob.query_tag_2 = 4'd7;
        #1;
        total++; if (rob.query_ready_1 !== BYP) begin bad++; $display("FAIL q_bypass_ready: got %0h want %0h", rob.query_ready_1, BYP); end
        if (BYP) begin
            total++; if (rob.query_value_1 !== 32'hBEEF) begin bad++; $display("FAIL q_bypass_value: got %0h want beef", rob.query_value_1); end
        end
        total++; if (rob.query_ready_2 !== 1'b0) begin bad++; $display("FAIL q_unissued: got %0h want 0", rob.query_ready_2); end
        step();
        rob.query_tag_1 = 4'd3;
        #1;
        total++; if (rob.query_ready_1 !== 1'b1) begin bad++; $display("FAIL q_stored_ready: got %0h want 1", rob.query_ready_1); end
        total++; if (rob.query_value_1 !== 32'hBEEF) begin bad++; $display("FAIL q_stored_value: got %0h want beef", rob.query_value_1); end
        step();
    endtask

    task automatic test_random();
        int           cand[$];
        int           k;
        int           idx;
        logic [31:0]  v;
        logic [W-1:0] t;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6)
                issue_one(2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom), $urandom);
            cand.delete();
            foreach (m_q[i]) if (!m_q[i].rdy) cand.push_back(i);
            for (int s = 0; s < 3; s++) begin
                if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                    k = $urandom_range(0, cand.size() - 1);
                    idx = cand[k];
                    cand.delete(k);
                    v = $urandom;
                    if (m_q[idx].kind == 2'd2)
                        v[0] = ($urandom_range(0, 3) != 0) ? m_q[idx].pred : ~m_q[idx].pred;
                    t = m_q[idx].tag;
                    case (s)
                        0: begin rob.done_alu_1 = 1'b1; rob.tag_alu_1 = t; rob.value_alu_1 = v; end
                        1: begin rob.done_alu_2 = 1'b1; rob.tag_alu_2 = t; rob.value_alu_2 = v; end
                        default: begin rob.done_lsb = 1'b1; rob.tag_lsb = t; rob.value_lsb = v; end
                    endcase
                end
            end
            rob.query_tag_1 = W'($urandom);
            rob.query_tag_2 = W'($urandom);
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_commit();
        test_full();
        test_out_of_order();
        test_mispredict();
        test_store();
        test_query();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
